// File: rtl/ibuf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ibuf_pkg
//  Description : Shared sizing helpers and status type for the input buffer
//                controller. Pointer and occupancy widths are derived from the
//                queue depth so every file sizes its vectors identically.
//  Contents    : ibuf_ptr_w()  - pointer width for a given depth
//                ibuf_cnt_w()  - occupancy width (must hold the value DEPTH)
//                ibuf_status_t - full / empty / almost-full flag bundle
//  Revision    : 1.0 - initial release
// ============================================================================
package ibuf_pkg;

    localparam int IBUF_DEFAULT_WIDTH = 16;
    localparam int IBUF_DEFAULT_DEPTH = 4;

    // Pointer indexes DEPTH entries; clamp at one bit for degenerate depths.
    function automatic int ibuf_ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy spans 0..DEPTH inclusive, hence one bit wider than the pointer.
    function automatic int ibuf_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
    } ibuf_status_t;

endpackage : ibuf_pkg
`default_nettype wire

// File: rtl/ibuf_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : ibuf_ptr
//  Description : Wrapping pointer counter for the input buffer. DEPTH is a
//                power of two, so the pointer wraps by natural overflow.
//                clr takes priority over inc.
//  Ports       : clk   - clock
//                reset - asynchronous active-high reset
//                clr   - synchronous clear to zero
//                inc   - advance pointer by one
//                ptr   - current pointer value
//  Revision    : 1.0 - initial release
// ============================================================================
module ibuf_ptr
    import ibuf_pkg::*;
#(
    parameter int DEPTH = IBUF_DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clr,
    input  logic                          inc,
    output logic [ibuf_ptr_w(DEPTH)-1:0]  ptr
);

    localparam int PTR_W = ibuf_ptr_w(DEPTH);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    assign ptr = r_ptr;

endmodule : ibuf_ptr
`default_nettype wire

// File: rtl/input_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : input_buffer_ctrl
//  Description : DEPTH-entry first-word-fall-through queue with valid/ready
//                handshakes on both sides. One-hot write strobes and one-hot
//                read selects drive DEPTH single-word registers. Occupancy,
//                an almost-full flag and a high-water mark are reported.
//  Ports       : clk, reset      - clock, async active-high reset
//                flush_i         - synchronous clear of pointers/count/hwm
//                in_data_i/in_valid_i/in_ready_o    - producer side
//                out_data_o/out_valid_o/out_ready_i - consumer side
//                count_o         - current occupancy
//                almost_full_o   - count_o >= AF_THRESH
//                hwm_o           - peak occupancy since reset/flush
//  Revision    : 1.0 - initial release
// ============================================================================
module input_buffer_ctrl
    import ibuf_pkg::*;
#(
    parameter int WIDTH     = IBUF_DEFAULT_WIDTH,
    parameter int DEPTH     = IBUF_DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_i,
    input  logic [WIDTH-1:0]              in_data_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [WIDTH-1:0]              out_data_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [ibuf_cnt_w(DEPTH)-1:0]  count_o,
    output logic                          almost_full_o,
    output logic [ibuf_cnt_w(DEPTH)-1:0]  hwm_o
);

    localparam int PTR_W = ibuf_ptr_w(DEPTH);
    localparam int CNT_W = ibuf_cnt_w(DEPTH);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    localparam cnt_t c_full = cnt_t'(DEPTH);
    localparam cnt_t c_af   = cnt_t'(AF_THRESH);

    cnt_t         r_count;
    cnt_t         r_hwm;
    cnt_t         w_count_nxt;
    ptr_t         w_wr_ptr;
    ptr_t         w_rd_ptr;
    ibuf_status_t w_status;

    logic w_push;
    logic w_pop;
    logic w_push_ok;
    logic w_pop_ok;

    logic [DEPTH-1:0]            w_wr_stb;
    logic [DEPTH-1:0]            w_rd_sel;
    logic [DEPTH-1:0][WIDTH-1:0] w_gated;
    logic [WIDTH-1:0]            w_rd_data;

    // ------------------------------------------------------------------
    // Flags come only from registered occupancy, so neither handshake
    // input has a combinational path to in_ready_o / out_valid_o.
    // ------------------------------------------------------------------
    assign w_status.full        = (r_count == c_full);
    assign w_status.empty       = (r_count == '0);
    assign w_status.almost_full = (r_count >= c_af);

    // No bypass: a full queue refuses the push even if a pop happens now.
    assign w_push = in_valid_i & ~w_status.full;
    assign w_pop  = out_ready_i & ~w_status.empty;

    // Flush discards whatever handshakes coincide with it.
    assign w_push_ok = w_push & ~flush_i;
    assign w_pop_ok  = w_pop  & ~flush_i;

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    ibuf_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush_i),
        .inc   (w_push_ok),
        .ptr   (w_wr_ptr)
    );

    ibuf_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush_i),
        .inc   (w_pop_ok),
        .ptr   (w_rd_ptr)
    );

    // ------------------------------------------------------------------
    // Occupancy and high-water mark
    // ------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + cnt_t'(1);
            2'b01:   w_count_nxt = r_count - cnt_t'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_hwm   <= '0;
        end else if (flush_i) begin
            r_count <= '0;
            r_hwm   <= '0;
        end else begin
            r_count <= w_count_nxt;
            // Track against the next count so the mark is never a cycle late.
            if (w_count_nxt > r_hwm) begin
                r_hwm <= w_count_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: one register per entry with its own strobe and read gate.
    // Flush leaves stored words intact; only reset clears them.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            logic [WIDTH-1:0] r_word;

            assign w_wr_stb[i] = w_push_ok & (w_wr_ptr == ptr_t'(i));
            assign w_rd_sel[i] = ~w_status.empty & (w_rd_ptr == ptr_t'(i));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_word <= '0;
                end else if (w_wr_stb[i]) begin
                    r_word <= in_data_i;
                end
            end

            assign w_gated[i] = w_rd_sel[i] ? r_word : '0;
        end
    endgenerate

    // Read select is one-hot (or all-zero when empty), so OR-ing the gated
    // entries acts as the output mux and yields zero on an empty queue.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_rd_data = w_rd_data | w_gated[k];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready_o    = ~w_status.full;
    assign out_valid_o   = ~w_status.empty;
    assign out_data_o    = w_rd_data;
    assign count_o       = r_count;
    assign almost_full_o = w_status.almost_full;
    assign hwm_o         = r_hwm;

endmodule : input_buffer_ctrl
`default_nettype wire

// File: tb/tb_input_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_buffer_ctrl
//  Description : Self-checking bench for input_buffer_ctrl (DEPTH=4,
//                WIDTH=16, AF_THRESH=3). Directed vectors with hand-computed
//                post-edge expectations, plus hand-written reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_buffer_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush_i;
    logic [WIDTH-1:0] in_data_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] out_data_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [CW-1:0]    count_o;
    logic             almost_full_o;
    logic [CW-1:0]    hwm_o;

    int total = 0;
    int bad   = 0;

    input_buffer_ctrl #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .in_data_i     (in_data_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .out_data_o    (out_data_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .count_o       (count_o),
        .almost_full_o (almost_full_o),
        .hwm_o         (hwm_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        flush;
        logic        ivalid;
        logic [15:0] idata;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic [15:0] e_data;
        logic [2:0]  e_cnt;
        logic        e_af;
        logic [2:0]  e_hwm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic flush, logic ivalid,
                                logic [15:0] idata, logic ordy, logic e_rdy,
                                logic e_vld, logic [15:0] e_data,
                                logic [2:0] e_cnt, logic e_af, logic [2:0] e_hwm);
        vec_t v;
        v.name   = name;   v.flush  = flush;  v.ivalid = ivalid;
        v.idata  = idata;  v.ordy   = ordy;   v.e_rdy  = e_rdy;
        v.e_vld  = e_vld;  v.e_data = e_data; v.e_cnt  = e_cnt;
        v.e_af   = e_af;   v.e_hwm  = e_hwm;
        return v;
    endfunction

    task automatic chk(string name, string field, logic [15:0] got, logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", name, field, got, want);
        end
    endtask

    task automatic check_outs(string name, logic rdy, logic vld, logic [15:0] data,
                              logic [2:0] cnt, logic af, logic [2:0] hwm);
        chk(name, "in_ready",    16'(in_ready_o),    16'(rdy));
        chk(name, "out_valid",   16'(out_valid_o),   16'(vld));
        chk(name, "out_data",    out_data_o,         data);
        chk(name, "count",       16'(count_o),       16'(cnt));
        chk(name, "almost_full", 16'(almost_full_o), 16'(af));
        chk(name, "hwm",         16'(hwm_o),         16'(hwm));
    endtask

    task automatic apply(vec_t v);
        flush_i     = v.flush;
        in_valid_i  = v.ivalid;
        in_data_i   = v.idata;
        out_ready_i = v.ordy;
        @(posedge clk);
        #1;
        check_outs(v.name, v.e_rdy, v.e_vld, v.e_data, v.e_cnt, v.e_af, v.e_hwm);
    endtask

    initial begin
        // name, flush, ivalid, idata, ordy | rdy, vld, data, cnt, af, hwm
        // Fill with consumer stalled.
        vecs.push_back(mk("fill1", 0, 1, 16'h1111, 0, 1, 1, 16'h1111, 3'd1, 0, 3'd1));
        vecs.push_back(mk("fill2", 0, 1, 16'h2222, 0, 1, 1, 16'h1111, 3'd2, 0, 3'd2));
        vecs.push_back(mk("fill3", 0, 1, 16'h3333, 0, 1, 1, 16'h1111, 3'd3, 1, 3'd3));
        vecs.push_back(mk("fill4", 0, 1, 16'h4444, 0, 0, 1, 16'h1111, 3'd4, 1, 3'd4));
        // Full: push refused while pop proceeds.
        vecs.push_back(mk("full_pp", 0, 1, 16'h5555, 1, 1, 1, 16'h2222, 3'd3, 1, 3'd4));
        vecs.push_back(mk("retry55", 0, 1, 16'h5555, 0, 0, 1, 16'h2222, 3'd4, 1, 3'd4));
        // Held valid with new data while full: nothing written.
        vecs.push_back(mk("hold66",  0, 1, 16'h6666, 0, 0, 1, 16'h2222, 3'd4, 1, 3'd4));
        // Drain.
        vecs.push_back(mk("drain1",  0, 0, 16'h0000, 1, 1, 1, 16'h3333, 3'd3, 1, 3'd4));
        vecs.push_back(mk("drain2",  0, 0, 16'h0000, 1, 1, 1, 16'h4444, 3'd2, 0, 3'd4));
        vecs.push_back(mk("drain3",  0, 0, 16'h0000, 1, 1, 1, 16'h5555, 3'd1, 0, 3'd4));
        vecs.push_back(mk("drain4",  0, 0, 16'h0000, 1, 1, 0, 16'h0000, 3'd0, 0, 3'd4));
        vecs.push_back(mk("flush_idle", 1, 0, 16'h0000, 0, 1, 0, 16'h0000, 3'd0, 0, 3'd0));
        // Streaming across pointer wrap.
        vecs.push_back(mk("stream0", 0, 1, 16'h0000, 1, 1, 1, 16'h0000, 3'd1, 0, 3'd1));
        for (int k = 1; k < 10; k++) begin
            vecs.push_back(mk($sformatf("stream%0d", k), 0, 1, 16'(k), 1,
                              1, 1, 16'(k), 3'd1, 0, 3'd1));
        end
        vecs.push_back(mk("stream_end", 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 3'd0, 0, 3'd1));
        // Flush priority over simultaneous push and pop.
        vecs.push_back(mk("fp_push1", 0, 1, 16'h0101, 0, 1, 1, 16'h0101, 3'd1, 0, 3'd1));
        vecs.push_back(mk("fp_push2", 0, 1, 16'h0202, 0, 1, 1, 16'h0101, 3'd2, 0, 3'd2));
        vecs.push_back(mk("fp_flush", 1, 1, 16'hAAAA, 1, 1, 0, 16'h0000, 3'd0, 0, 3'd0));
        vecs.push_back(mk("fp_idle",  0, 0, 16'h0000, 1, 1, 0, 16'h0000, 3'd0, 0, 3'd0));
        vecs.push_back(mk("fp_push3", 0, 1, 16'h0303, 0, 1, 1, 16'h0303, 3'd1, 0, 3'd1));
        vecs.push_back(mk("fp_pop3",  0, 0, 16'h0000, 1, 1, 0, 16'h0000, 3'd0, 0, 3'd1));

        // Reset.
        reset       = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        #12;
        reset = 1'b0;
        #4;
        check_outs("reset", 1, 0, 16'h0000, 3'd0, 0, 3'd0);

        foreach (vecs[i]) apply(vecs[i]);

        // Async reset mid-operation at count 3.
        apply(mk("ar_push1", 0, 1, 16'h0C01, 0, 1, 1, 16'h0C01, 3'd1, 0, 3'd1));
        apply(mk("ar_push2", 0, 1, 16'h0C02, 0, 1, 1, 16'h0C01, 3'd2, 0, 3'd2));
        apply(mk("ar_push3", 0, 1, 16'h0C03, 0, 1, 1, 16'h0C01, 3'd3, 1, 3'd3));
        #3;
        in_valid_i = 1'b0;
        reset      = 1'b1;
        #1;
        check_outs("ar_async", 1, 0, 16'h0000, 3'd0, 0, 3'd0);
        #1;
        reset = 1'b0;
        apply(mk("ar_beef",  0, 1, 16'hBEEF, 0, 1, 1, 16'hBEEF, 3'd1, 0, 3'd1));
        apply(mk("ar_alone", 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 3'd0, 0, 3'd1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_input_buffer_ctrl
`default_nettype wire
